// File: rtl/shift_register_seq_pkg.sv
// Shared encodings for the sequenced shift register: the shift modes and the run-control FSM states.
package shift_register_seq_pkg;

  localparam logic [1:0] OP_SHL1  = 2'b00;
  localparam logic [1:0] OP_SHR1  = 2'b01;
  localparam logic [1:0] OP_SQRT2 = 2'b10;
  localparam logic [1:0] OP_ASR1  = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

endpackage

// File: rtl/shift_register_seq_shift_unit.sv
// Combinational one-step shifter that computes the next Q, the next pair and the removed bit for a given mode.
module shift_unit
  import shift_register_seq_pkg::*;
#(
  parameter int WORD_LENGTH = 16
) (
  input  logic [WORD_LENGTH-1:0] q_in,
  input  logic [1:0]             pair_in,
  input  logic [1:0]             op,
  output logic [WORD_LENGTH-1:0] q_next,
  output logic [1:0]             pair_next,
  output logic                   bit_next
);

  // pair only changes in SQRT2 mode; every other mode carries it through
  always_comb begin
    q_next    = q_in;
    pair_next = pair_in;
    bit_next  = 1'b0;
    case (op)
      OP_SHL1: begin
        q_next   = {q_in[WORD_LENGTH-2:0], 1'b0};
        bit_next = q_in[WORD_LENGTH-1];
      end
      OP_SHR1: begin
        q_next   = {1'b0, q_in[WORD_LENGTH-1:1]};
        bit_next = q_in[0];
      end
      OP_SQRT2: begin
        q_next    = {q_in[WORD_LENGTH-3:0], 2'b00};
        pair_next = q_in[WORD_LENGTH-1:WORD_LENGTH-2];
        bit_next  = q_in[WORD_LENGTH-1];
      end
      OP_ASR1: begin
        q_next   = {q_in[WORD_LENGTH-1], q_in[WORD_LENGTH-1:1]};
        bit_next = q_in[0];
      end
      default: begin
        q_next    = q_in;
        pair_next = pair_in;
        bit_next  = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/shift_register_seq.sv
// Operand shift register with single-step shifts and an autonomous N-step run reported through busy/done.
module shift_register_seq
  import shift_register_seq_pkg::*;
#(
  parameter  int WORD_LENGTH = 16,
  localparam int CNT_W       = $clog2(WORD_LENGTH) + 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [WORD_LENGTH-1:0] D,
  input  logic                   load,
  input  logic                   start,
  input  logic                   shift,
  input  logic [1:0]             op,
  input  logic [CNT_W-1:0]       steps,
  output logic [WORD_LENGTH-1:0] Q,
  output logic [1:0]             pair,
  output logic                   bit_out,
  output logic [CNT_W-1:0]       step_cnt,
  output logic                   busy,
  output logic                   done
);

  state_t                 state_r;
  logic [WORD_LENGTH-1:0] q_r;
  logic [1:0]             pair_r;
  logic                   bit_out_r;
  logic [CNT_W-1:0]       step_cnt_r;
  logic [1:0]             op_r;
  logic [CNT_W-1:0]       steps_r;

  logic [1:0]             op_sel_s;
  logic [WORD_LENGTH-1:0] q_next_s;
  logic [1:0]             pair_next_s;
  logic                   bit_next_s;
  logic [CNT_W-1:0]       cnt_inc_s;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  // A run uses the mode latched at start so op changes mid-run cannot disturb it
  assign op_sel_s  = (state_r == RUN) ? op_r : op;
  assign cnt_inc_s = sat_inc(step_cnt_r);

  shift_unit #(
    .WORD_LENGTH(WORD_LENGTH)
  ) u_shift_unit (
    .q_in      (q_r),
    .pair_in   (pair_r),
    .op        (op_sel_s),
    .q_next    (q_next_s),
    .pair_next (pair_next_s),
    .bit_next  (bit_next_s)
  );

  // Run-control FSM together with the operand, pair, bit and step-count registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= IDLE;
      q_r        <= {WORD_LENGTH{1'b0}};
      pair_r     <= 2'b00;
      bit_out_r  <= 1'b0;
      step_cnt_r <= {CNT_W{1'b0}};
      op_r       <= 2'b00;
      steps_r    <= {CNT_W{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (load) begin
            q_r        <= D;
            pair_r     <= 2'b00;
            bit_out_r  <= 1'b0;
            step_cnt_r <= {CNT_W{1'b0}};
          end else if (start) begin
            step_cnt_r <= {CNT_W{1'b0}};
            if (steps == {CNT_W{1'b0}}) begin
              state_r <= DONE;
            end else begin
              op_r    <= op;
              steps_r <= steps;
              state_r <= RUN;
            end
          end else if (shift) begin
            q_r        <= q_next_s;
            pair_r     <= pair_next_s;
            bit_out_r  <= bit_next_s;
            step_cnt_r <= cnt_inc_s;
          end else begin
            state_r <= IDLE;
          end
        end
        RUN: begin
          if (load) begin
            q_r        <= D;
            pair_r     <= 2'b00;
            bit_out_r  <= 1'b0;
            step_cnt_r <= {CNT_W{1'b0}};
            state_r    <= IDLE;
          end else begin
            q_r        <= q_next_s;
            pair_r     <= pair_next_s;
            bit_out_r  <= bit_next_s;
            step_cnt_r <= cnt_inc_s;
            if (cnt_inc_s == steps_r) begin
              state_r <= DONE;
            end else begin
              state_r <= RUN;
            end
          end
        end
        DONE: begin
          if (load) begin
            q_r        <= D;
            pair_r     <= 2'b00;
            bit_out_r  <= 1'b0;
            step_cnt_r <= {CNT_W{1'b0}};
          end else begin
            q_r <= q_r;
          end
          state_r <= IDLE;
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign Q        = q_r;
  assign pair     = pair_r;
  assign bit_out  = bit_out_r;
  assign step_cnt = step_cnt_r;
  assign busy     = (state_r == RUN);
  assign done     = (state_r == DONE);

endmodule

// File: tb/tb_shift_register_seq.sv
// Table-driven scoreboard bench for shift_register_seq at WORD_LENGTH=8, plus a hand-written long ASR run.
module tb_shift_register_seq;
  localparam int W  = 8;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          reset, load, start, shift;
  logic [1:0]    op;
  logic [CW-1:0] steps;
  logic [W-1:0]  D, Q;
  logic [1:0]    pair;
  logic          bit_out;
  logic [CW-1:0] step_cnt;
  logic          busy, done;

  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    string name;
    logic rst, ld, st, sh;
    logic [1:0] op; logic [CW-1:0] steps; logic [W-1:0] d;
    logic [W-1:0] q; logic [1:0] pair; logic bo; logic [CW-1:0] cnt; logic busy, done;
  } vec_t;

  typedef struct {
    string name;
    logic [W-1:0] q; logic [1:0] pair; logic bo; logic [CW-1:0] cnt; logic busy, done;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];

  shift_register_seq #(.WORD_LENGTH(W)) dut (
    .clk(clk), .reset(reset), .D(D), .load(load), .start(start), .shift(shift),
    .op(op), .steps(steps), .Q(Q), .pair(pair), .bit_out(bit_out),
    .step_cnt(step_cnt), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  function automatic vec_t v(string name, logic rst, logic ld, logic st, logic sh,
                             logic [1:0] o, logic [CW-1:0] n, logic [W-1:0] d,
                             logic [W-1:0] q, logic [1:0] p, logic bo,
                             logic [CW-1:0] cnt, logic bsy, logic dn);
    vec_t r;
    r.name = name; r.rst = rst; r.ld = ld; r.st = st; r.sh = sh;
    r.op = o; r.steps = n; r.d = d;
    r.q = q; r.pair = p; r.bo = bo; r.cnt = cnt; r.busy = bsy; r.done = dn;
    return r;
  endfunction

  task automatic apply(input vec_t t);
    exp_t e;
    @(negedge clk);
    reset = t.rst; load = t.ld; start = t.st; shift = t.sh;
    op = t.op; steps = t.steps; D = t.d;
    e.name = t.name; e.q = t.q; e.pair = t.pair; e.bo = t.bo;
    e.cnt = t.cnt; e.busy = t.busy; e.done = t.done;
    sb.push_back(e);
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  // Scoreboard: each edge's outputs are compared against the record pushed before it
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      n_vec++;
      if ({Q, pair, bit_out, step_cnt, busy, done} !== {e.q, e.pair, e.bo, e.cnt, e.busy, e.done}) begin
        n_bad++;
        $display("FAIL %s: got Q=%h pair=%b bit_out=%b step_cnt=%0d busy=%b done=%b, want Q=%h pair=%b bit_out=%b step_cnt=%0d busy=%b done=%b",
                 e.name, Q, pair, bit_out, step_cnt, busy, done,
                 e.q, e.pair, e.bo, e.cnt, e.busy, e.done);
      end
    end
  end

  initial begin
    int  nbusy;
    bit  seen;
    reset = 1'b0; load = 1'b0; start = 1'b0; shift = 1'b0;
    op = 2'b00; steps = 4'd0; D = 8'h00;

    //          name            rst  ld   st   sh   op     steps d       Q      pair   bo   cnt   busy done
    tbl.push_back(v("reset0",    1'b1,1'b1,1'b1,1'b1,2'b11,4'd5, 8'hFF, 8'h00,2'b00,1'b0,4'd0,1'b0,1'b0));
    tbl.push_back(v("reset1",    1'b1,1'b0,1'b1,1'b1,2'b10,4'd3, 8'hA5, 8'h00,2'b00,1'b0,4'd0,1'b0,1'b0));
    tbl.push_back(v("ld_b5",     1'b0,1'b1,1'b0,1'b0,2'b00,4'd0, 8'hB5, 8'hB5,2'b00,1'b0,4'd0,1'b0,1'b0));
    tbl.push_back(v("shl_step",  1'b0,1'b0,1'b0,1'b1,2'b00,4'd0, 8'h00, 8'h6A,2'b00,1'b1,4'd1,1'b0,1'b0));
    tbl.push_back(v("shl_hold",  1'b0,1'b0,1'b0,1'b0,2'b00,4'd0, 8'h00, 8'h6A,2'b00,1'b1,4'd1,1'b0,1'b0));
    tbl.push_back(v("sq_ld",     1'b0,1'b1,1'b0,1'b0,2'b10,4'd0, 8'hB5, 8'hB5,2'b00,1'b0,4'd0,1'b0,1'b0));
    tbl.push_back(v("sq_start",  1'b0,1'b0,1'b1,1'b0,2'b10,4'd4, 8'h00, 8'hB5,2'b00,1'b0,4'd0,1'b1,1'b0));
    tbl.push_back(v("sq_s1",     1'b0,1'b0,1'b0,1'b0,2'b10,4'd0, 8'h00, 8'hD4,2'b10,1'b1,4'd1,1'b1,1'b0));
    tbl.push_back(v("sq_s2",     1'b0,1'b0,1'b0,1'b0,2'b10,4'd0, 8'h00, 8'h50,2'b11,1'b1,4'd2,1'b1,1'b0));
    tbl.push_back(v("sq_s3",     1'b0,1'b0,1'b0,1'b0,2'b10,4'd0, 8'h00, 8'h40,2'b01,1'b0,4'd3,1'b1,1'b0));
    tbl.push_back(v("sq_s4done", 1'b0,1'b0,1'b0,1'b0,2'b10,4'd0, 8'h00, 8'h00,2'b01,1'b0,4'd4,1'b0,1'b1));
    tbl.push_back(v("sq_idle",   1'b0,1'b0,1'b0,1'b0,2'b10,4'd0, 8'h00, 8'h00,2'b01,1'b0,4'd4,1'b0,1'b0));
    tbl.push_back(v("asr_ld",    1'b0,1'b1,1'b0,1'b0,2'b11,4'd0, 8'h90, 8'h90,2'b00,1'b0,4'd0,1'b0,1'b0));
    tbl.push_back(v("asr_start", 1'b0,1'b0,1'b1,1'b0,2'b11,4'd3, 8'h00, 8'h90,2'b00,1'b0,4'd0,1'b1,1'b0));
    tbl.push_back(v("asr_s1",    1'b0,1'b0,1'b0,1'b0,2'b11,4'd0, 8'h00, 8'hC8,2'b00,1'b0,4'd1,1'b1,1'b0));
    tbl.push_back(v("asr_s2flip",1'b0,1'b0,1'b0,1'b0,2'b00,4'd0, 8'h00, 8'hE4,2'b00,1'b0,4'd2,1'b1,1'b0));
    tbl.push_back(v("asr_s3done",1'b0,1'b0,1'b1,1'b1,2'b00,4'd9, 8'h00, 8'hF2,2'b00,1'b0,4'd3,1'b0,1'b1));
    tbl.push_back(v("asr_idle",  1'b0,1'b0,1'b0,1'b0,2'b00,4'd0, 8'h00, 8'hF2,2'b00,1'b0,4'd3,1'b0,1'b0));
    tbl.push_back(v("ab_ld",     1'b0,1'b1,1'b0,1'b0,2'b00,4'd0, 8'h01, 8'h01,2'b00,1'b0,4'd0,1'b0,1'b0));
    tbl.push_back(v("ab_start",  1'b0,1'b0,1'b1,1'b0,2'b00,4'd6, 8'h00, 8'h01,2'b00,1'b0,4'd0,1'b1,1'b0));
    tbl.push_back(v("ab_s1",     1'b0,1'b0,1'b1,1'b0,2'b01,4'd2, 8'h00, 8'h02,2'b00,1'b0,4'd1,1'b1,1'b0));
    tbl.push_back(v("ab_load",   1'b0,1'b1,1'b0,1'b0,2'b00,4'd0, 8'h3C, 8'h3C,2'b00,1'b0,4'd0,1'b0,1'b0));
    tbl.push_back(v("ab_idle",   1'b0,1'b0,1'b0,1'b0,2'b00,4'd0, 8'h00, 8'h3C,2'b00,1'b0,4'd0,1'b0,1'b0));
    tbl.push_back(v("z_start",   1'b0,1'b0,1'b1,1'b0,2'b00,4'd0, 8'h00, 8'h3C,2'b00,1'b0,4'd0,1'b0,1'b1));
    tbl.push_back(v("z_ign_sh",  1'b0,1'b0,1'b0,1'b1,2'b00,4'd0, 8'h00, 8'h3C,2'b00,1'b0,4'd0,1'b0,1'b0));
    tbl.push_back(v("z2_start",  1'b0,1'b0,1'b1,1'b0,2'b01,4'd0, 8'h00, 8'h3C,2'b00,1'b0,4'd0,1'b0,1'b1));
    tbl.push_back(v("z2_ld_done",1'b0,1'b1,1'b0,1'b0,2'b01,4'd0, 8'hA5, 8'hA5,2'b00,1'b0,4'd0,1'b0,1'b0));
    tbl.push_back(v("shr_step",  1'b0,1'b0,1'b0,1'b1,2'b01,4'd0, 8'h00, 8'h52,2'b00,1'b1,4'd1,1'b0,1'b0));
    tbl.push_back(v("rr_ld",     1'b0,1'b1,1'b0,1'b0,2'b01,4'd0, 8'h81, 8'h81,2'b00,1'b0,4'd0,1'b0,1'b0));
    tbl.push_back(v("rr_start",  1'b0,1'b0,1'b1,1'b0,2'b01,4'd5, 8'h00, 8'h81,2'b00,1'b0,4'd0,1'b1,1'b0));
    tbl.push_back(v("rr_s1",     1'b0,1'b0,1'b0,1'b0,2'b01,4'd0, 8'h00, 8'h40,2'b00,1'b1,4'd1,1'b1,1'b0));
    tbl.push_back(v("rr_reset",  1'b1,1'b0,1'b0,1'b0,2'b01,4'd0, 8'h00, 8'h00,2'b00,1'b0,4'd0,1'b0,1'b0));
    tbl.push_back(v("rr_idle",   1'b0,1'b0,1'b0,1'b0,2'b01,4'd0, 8'h00, 8'h00,2'b00,1'b0,4'd0,1'b0,1'b0));
    tbl.push_back(v("lx_ld",     1'b0,1'b1,1'b0,1'b0,2'b11,4'd0, 8'h80, 8'h80,2'b00,1'b0,4'd0,1'b0,1'b0));

    for (int i = 0; i < tbl.size(); i++) apply(tbl[i]);
    @(negedge clk);
    reset = 1'b0; load = 1'b0; start = 1'b0; shift = 1'b0;
    @(posedge clk);
    #2;

    // Run longer than the word: ASR keeps filling with the sign bit
    nbusy = 0;
    seen  = 1'b0;
    @(negedge clk);
    op = 2'b11; steps = 4'd10; start = 1'b1;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(posedge clk);
      #1;
      start = 1'b0;
      op    = 2'b00;
      if (busy) nbusy++;
      if (done) seen = 1'b1;
    end
    check("lx_done_seen", int'(seen), 1);
    check("lx_busy_cycles", nbusy, 10);
    check("lx_q", int'(Q), 8'hFF);
    check("lx_bit_out", int'(bit_out), 1);
    check("lx_step_cnt", int'(step_cnt), 10);
    @(posedge clk);
    #1;
    check("lx_done_pulse", int'(done), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/shift_register_seq.md
Name: shift_register_seq

Overview:
Parametrised successor to the team's mult/sqrt shift register. Holds a WORD_LENGTH operand and shifts it in one of four modes: multiply (shift left 1), logical right 1, arithmetic right 1, or sqrt bit-pair extraction (shift left 2 and expose the pair). It supports single-step shifts or an autonomous N-step run with a busy/done handshake, so the multiplier and square-root FSMs no longer need per-step shift counting.

Parameters:
WORD_LENGTH, 16, operand width; must be even and >= 4 (sqrt mode consumes pairs).
CNT_W, localparam = $clog2(WORD_LENGTH)+1, width of step counters.

Ports:
clk  input  1  clock, rising edge.
reset  input  1  synchronous, active-high reset.
D  input  WORD_LENGTH  parallel load data.
load  input  1  capture D into Q.
start  input  1  begin autonomous run of `steps` shifts.
shift  input  1  single shift step when idle.
op  input  2  mode: 00 SHL1, 01 SHR1, 10 SQRT2, 11 ASR1.
steps  input  CNT_W  shift count for run; sampled at start.
Q  output  WORD_LENGTH  register contents.
pair  output  2  bit pair removed by the most recent SQRT2 shift.
bit_out  output  1  MSB (SHL1, SQRT2) or LSB (SHR1, ASR1) removed by the most recent shift.
step_cnt  output  CNT_W  shifts done since last load/start; saturates at all-ones.
busy  output  1  high while in RUN.
done  output  1  one-cycle pulse at run completion.

Behaviour:
- All state is registered. On reset=1 at a clock edge: Q=0, pair=0, bit_out=0, step_cnt=0, busy=0, done=0, state=IDLE. Reset overrides all other inputs, including mid-run.
- Priority per edge: reset > load > start > shift.
- Shift ops (W=WORD_LENGTH):
  - SHL1: Q<={Q[W-2:0],0}; bit_out<=Q[W-1].
  - SHR1: Q<={0,Q[W-1:1]}; bit_out<=Q[0].
  - ASR1: Q<={Q[W-1],Q[W-1:1]}; bit_out<=Q[0].
  - SQRT2: Q<={Q[W-3:0],00}; pair<=Q[W-1:W-2]; bit_out<=Q[W-1].
  - pair holds its value in non-SQRT2 modes.
- FSM states: IDLE, RUN, DONE.
  - IDLE:
    - load: Q<=D; pair, bit_out, step_cnt <=0.
    - start with steps==0: step_cnt<=0 -> DONE, no shift.
    - start with steps>0: latch op_q<=op, steps_q<=steps, step_cnt<=0 -> RUN.
    - shift (no load/start): one shift using live op; step_cnt++ (saturating).
  - RUN:
    - One shift per cycle using op_q. Changes on op/steps/shift during a run are ignored.
    - step_cnt++ each cycle; after the shift that makes step_cnt==steps_q -> DONE.
    - start and shift are ignored.
    - load aborts: Q<=D, pair/bit_out/step_cnt<=0, -> IDLE, no done pulse.
  - DONE: done=1 for exactly this cycle, busy=0. Next state IDLE. load is honoured (as in IDLE). start and shift are ignored.
- Latency: start sampled at edge E; shifts occur at edges E+1..E+N; state=DONE (done=1) between edges E+N and E+N+1. busy is high for exactly N cycles. For steps==0, done is high between E+1 and E+2... no: DONE is entered at edge E, so done is high between E and E+1, and Q is unchanged.
- steps > W (or > W/2 in SQRT2) is legal: extra shifts fill zeros (or sign bits for ASR1).
- busy = (state==RUN); done = (state==DONE); both are registered-state decodes, with no combinational path from inputs.

Decomposition:
- Package shift_register_seq_pkg holds:
  - op encodings: OP_SHL1=2'b00, OP_SHR1=2'b01, OP_SQRT2=2'b10, OP_ASR1=2'b11.
  - FSM state encoding: IDLE, RUN, DONE.
- One sub-module, shift_unit: a combinational next-Q/pair/bit_out function of (Q, op). It is reused for single-step and run paths.
- FSM, counters and registers stay in the top module.

Test Plan:
- W=8. Assert reset for 2 cycles, all inputs toggling -> Q=0x00, pair=0, bit_out=0, step_cnt=0, busy=0, done=0.
- Load 0xB5, op=00, one shift pulse -> Q=0x6A, bit_out=1, step_cnt=1, busy stays 0, no done.
- Load 0xB5, op=10, start steps=4 -> pair sequence 10,11,01,01; final Q=0x00. busy high exactly 4 cycles, done a single pulse right after, step_cnt=4.
- Load 0x90, op=11, start steps=3; flip op to 00 after 1 cycle -> Q sequence 0xC8, 0xE4, 0xF2; bit_out=0; done pulses once.
- Run op=00 steps=6 from 0x01; assert load D=0x3C on 2nd RUN cycle -> Q=0x3C, busy=0, step_cnt=0, no done pulse; start during RUN has no effect.
- start steps=0 -> done pulse the next cycle, busy never high, Q unchanged. Separately, assert reset mid-run -> all outputs 0, IDLE, no done.
